ula_sequenciador_nibble: RTL

Multi-cycle controller that sits directly upstream of the 4-bit adder/subtractor and widens it to 4·N_NIBBLES-bit operands. It latches a full-width operation on `start` and feeds the adder one nibble per cycle, LSB nibble first, chaining the carry through a register. It collects the partial sums and presents a registered full-width result with carry, signed-overflow and zero flags.

---
 rtl/ula_sequenciador_nibble_pkg.sv | 25 ++
 rtl/ula_sequenciador_nibble_if.sv | 38 +++
 rtl/ula_sequenciador_nibble_somador.sv | 26 ++
 rtl/ula_sequenciador_nibble.sv | 130 +++++++++++++
 4 files changed

// File: rtl/ula_sequenciador_nibble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ula_pkg
// Brief    : Shared constants and types for the nibble-serial ALU sequencer:
//            FSM state encoding, nibble width and operation codes.
// Revision : 1.0 - initial release
// ============================================================================
package ula_pkg;

  // Width of one slice handled by the 4-bit adder/subtractor
  localparam int NIBBLE = 4;

  // Operation codes carried on modo_sub
  localparam logic OP_SOMA = 1'b0;
  localparam logic OP_SUB  = 1'b1;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : ula_pkg
`default_nettype wire

// File: rtl/ula_sequenciador_nibble_if.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequenciador_nibble_if
// Brief    : Request/result bundle of the nibble-serial ALU sequencer.
//            master = requester, slave = sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface ula_sequenciador_nibble_if
  import ula_pkg::*;
#(
  parameter int N_NIBBLES = 2
) ();

  localparam int W = NIBBLE * N_NIBBLES;

  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         modo_sub;
  logic         busy;
  logic         done;
  logic [W-1:0] resultado;
  logic         cout;
  logic         ov;
  logic         zero;

  modport master (
    output start, a_in, b_in, modo_sub,
    input  busy, done, resultado, cout, ov, zero
  );

  modport slave (
    input  start, a_in, b_in, modo_sub,
    output busy, done, resultado, cout, ov, zero
  );

endinterface : ula_sequenciador_nibble_if
`default_nettype wire

// File: rtl/ula_sequenciador_nibble_somador.sv
`default_nettype none
// ============================================================================
// Module   : somador_subtrator_4bits
// Brief    : 4-bit adder/subtractor. In subtract mode B is inverted; the +1
//            of two's complement comes in through cin_inicial.
// Revision : 1.0 - initial release
// ============================================================================
module somador_subtrator_4bits
  import ula_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              modo_sub,
  input  logic              cin_inicial,
  output logic [NIBBLE:0]   s,
  output logic              ov
);

  logic [NIBBLE-1:0] b_eff;

  assign b_eff = b ^ {NIBBLE{modo_sub}};
  assign s     = {1'b0, a} + {1'b0, b_eff} + {{NIBBLE{1'b0}}, cin_inicial};
  assign ov    = (a[NIBBLE-1] == b_eff[NIBBLE-1]) && (s[NIBBLE-1] != a[NIBBLE-1]);

endmodule : somador_subtrator_4bits
`default_nettype wire

// File: rtl/ula_sequenciador_nibble.sv
`default_nettype none
// ============================================================================
// Module   : ula_sequenciador_nibble
// Brief    : Widens a 4-bit adder/subtractor to 4*N_NIBBLES bits by feeding
//            it one nibble per cycle (LSB first) with a registered carry
//            chain, then publishes result, carry, overflow and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module ula_sequenciador_nibble
  import ula_pkg::*;
#(
  parameter int N_NIBBLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  ula_sequenciador_nibble_if.slave  bus
);

  localparam int              W      = NIBBLE * N_NIBBLES;
  localparam int              KW     = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(N_NIBBLES - 1);

  state_t            state;
  state_t            state_nxt;
  logic [W-1:0]      a_r;
  logic [W-1:0]      b_r;
  logic              modo_r;
  logic [KW-1:0]     k;
  logic              carry_r;
  logic [W-1:0]      shadow;
  logic [W-1:0]      full;
  logic [W-1:0]      resultado_r;
  logic              cout_r;
  logic              ov_r;
  logic              zero_r;
  logic [NIBBLE-1:0] nib_a;
  logic [NIBBLE-1:0] nib_b;
  logic [NIBBLE:0]   s;
  logic              adder_ov_unused;
  logic              last;
  logic              b_msb_eff;

  assign nib_a     = a_r[k*NIBBLE +: NIBBLE];
  assign nib_b     = b_r[k*NIBBLE +: NIBBLE];
  assign last      = (state == ST_CALC) && (k == K_LAST);
  // Effective MSB of the second operand after the subtract inversion
  assign b_msb_eff = b_r[W-1] ^ modo_r;

  somador_subtrator_4bits u_somador (
    .a           (nib_a),
    .b           (nib_b),
    .modo_sub    (modo_r),
    .cin_inicial (carry_r),
    .s           (s),
    .ov          (adder_ov_unused)
  );

  // Shadow with the nibble being processed this cycle already merged in
  always_comb begin
    full = shadow;
    full[k*NIBBLE +: NIBBLE] = s[NIBBLE-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, walk nibbles in CALC, one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start) state_nxt = ST_CALC;
      ST_CALC: if (k == K_LAST) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, nibble walk, carry chain and result publication
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= '0;
      b_r         <= '0;
      modo_r      <= 1'b0;
      k           <= '0;
      carry_r     <= 1'b0;
      shadow      <= '0;
      resultado_r <= '0;
      cout_r      <= 1'b0;
      ov_r        <= 1'b0;
      zero_r      <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a_in;
            b_r     <= bus.b_in;
            modo_r  <= bus.modo_sub;
            k       <= '0;
            carry_r <= (bus.modo_sub == OP_SUB);
          end
        end
        ST_CALC: begin
          shadow  <= full;
          carry_r <= s[NIBBLE];
          if (last) begin
            resultado_r <= full;
            cout_r      <= s[NIBBLE];
            ov_r        <= (a_r[W-1] == b_msb_eff) && (full[W-1] != a_r[W-1]);
            zero_r      <= (full == '0);
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == ST_CALC);
  assign bus.done      = (state == ST_DONE);
  assign bus.resultado = resultado_r;
  assign bus.cout      = cout_r;
  assign bus.ov        = ov_r;
  assign bus.zero      = zero_r;

endmodule : ula_sequenciador_nibble
`default_nettype wire
